// File: rtl/call_stack.sv
// call_stack: LIFO return-address stack (push/pop/replace-top, wrap or saturate); ports clk, rst, push, pop, clear_err, din -> dout, count, empty, full, overflow, underflow
module call_stack #(
  parameter int WIDTH      = 13,
  parameter int DEPTH_LOG2 = 3,
  parameter int WRAP       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear_err,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;
  logic                  r_unf;
  logic [DEPTH_LOG2-1:0] w_top;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wrap;
  logic                  w_ovf;
  logic                  w_unf;
  assign w_wrap    = WRAP != 0;
  assign w_top     = r_ptr - 1'b1;
  assign w_full    = r_count == DEPTH[DEPTH_LOG2:0];
  assign w_empty   = r_count == '0;
  assign w_ovf     = push & ~pop & w_full;
  assign w_unf     = pop & ~push & w_empty;
  assign dout      = r_mem[w_top];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (push && pop && !w_empty) begin
        r_mem[w_top] <= din;
      end else if (push && (!w_full || w_wrap)) begin
        r_mem[r_ptr] <= din;
        r_ptr        <= r_ptr + 1'b1;
        if (!w_full) r_count <= r_count + 1'b1;
      end else if (pop && !push && (!w_empty || w_wrap)) begin
        r_ptr <= r_ptr - 1'b1;
        if (!w_empty) r_count <= r_count - 1'b1;
      end
      r_ovf <= (r_ovf & ~clear_err) | w_ovf;
      r_unf <= (r_unf & ~clear_err) | w_unf;
    end
  end
endmodule
